rr_mux_reg: RTL and testbench
=============================

// Module: rr_mux_reg
// PURPOSE
//  Registered N-channel arbitrating mux with valid/ready handshakes on both sides.
//  Selects one of NCH requesting sources per cycle, either round-robin or fixed-priority,
//  and holds the chosen word in an output register until the consumer accepts it.
//  Used where several pipeline producers share one downstream path (e.g. a writeback
//  or forwarding port). Successor to the combinational mux2/mux3/mux4 select logic.
// PARAMETERS
//  WIDTH  8  data bits per channel
//  NCH    4  number of input channels; legal range 2..16
//  MODE   0  0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
//  SELW   localparam = max(1, clog2(NCH)); width of the channel index
// PORTS
//  clk        in   1          clock, all state on rising edge
//  reset      in   1          asynchronous, active-high reset
//  in_valid   in   NCH        per-channel request; bit i is channel i
//  in_data    in   NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_ready   out  NCH        per-channel accept; at most one bit set (one-hot or zero)
//  out_valid  out  1          output register holds a valid word
//  out_data   out  WIDTH      registered selected data
//  out_sel    out  SELW       index of the channel that supplied out_data
//  out_ready  in   1          consumer accepts out_data this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr pointer=0.
//    Reset mid-operation drops the held word; no source handshake completes in that cycle.
//  - load = ~out_valid | out_ready (register empty or drained this cycle).
//  - Grant g (combinational from in_valid and pointer):
//      MODE 0: first set in_valid bit searching ptr, ptr+1, ... wrapping at NCH-1 -> 0.
//      MODE 1: lowest-index set in_valid bit; pointer unused and held at 0.
//  - in_ready[i] = load & any(in_valid) & (i == g). A transfer on channel i completes
//    when in_valid[i] & in_ready[i]. in_ready may depend on in_valid (no comb loop
//    permitted through out_ready into any source's in_valid).
//  - Transfer cycle: out_valid<=1, out_data<=word of g, out_sel<=g; MODE 0: ptr<=(g+1)%NCH.
//  - load with no in_valid: out_valid<=0; out_data/out_sel hold old values; ptr holds.
//  - ~load (out_valid & ~out_ready): out_valid/out_data/out_sel hold stable; in_ready=0;
//    ptr holds.
//  - Latency: accepted input appears on out_data the next cycle. Throughput: one word
//    per cycle while out_ready=1 and any channel requests.
//  - Fairness (MODE 0): with all channels continuously valid and out_ready=1, grants
//    cycle 0,1,..,NCH-1,0,.. ; any continuously requesting channel waits <= NCH-1 grants.
//  - Pointer advances only on a completed transfer, never on idle or stall cycles.
//  - Non-power-of-two NCH: pointer wraps from NCH-1 to 0; indices >= NCH never granted.
// TESTING
//  1. Reset: assert reset with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0,
//     in_ready=0 during reset; first grant after release is channel 0.
//  2. MODE 0, NCH=4, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence
//     0,1,2,3,0,1,2,3, out_data matches each channel's word, one word per cycle.
//  3. Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_sel stable,
//     in_ready=4'b0000; out_ready=1 -> next granted word loads the following cycle.
//  4. Sparse RR: ptr=2, in_valid=4'b0011 -> grant channel 0, ptr becomes 1; next cycle
//     in_valid=4'b0011 -> grant channel 1, ptr wraps to 2.
//  5. MODE 1, in_valid=4'b1010 continuous -> channel 1 always granted, channel 3 starved;
//     in_valid=4'b1000 -> channel 3 granted.
//  6. Idle drain: single word held, out_ready=1, in_valid=0 -> out_valid drops to 0 next
//     cycle, out_data holds last value, ptr unchanged.

Source files
------------

// File: rtl/rr_mux_reg.sv
// Registered N-channel arbitrating mux: round-robin or fixed-priority grant,
// valid/ready on both sides, one-entry output register.
module rr_mux_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_sel,
    input  logic                   out_ready
);

    logic [WIDTH-1:0] words [NCH];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic             load;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic             transfer;

    for (genvar i = 0; i < NCH; i++) begin : g_words
        assign words[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign load = ~out_valid_q | out_ready;

    // Search starts at ptr and wraps at NCH; in fixed-priority mode ptr stays 0,
    // so the same search degenerates to lowest-index-wins.
    always_comb begin
        logic [SELW:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, ptr_q} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(NCH)) begin
                cand = cand - (SELW+1)'(NCH);
            end
            if (!grant_valid && in_valid[cand[SELW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[SELW-1:0];
            end
        end
    end

    // Reset gates the handshake so no source sees an accept while the register is cleared.
    assign transfer = load & grant_valid & ~reset;
    assign in_ready = transfer ? (NCH'(1) << grant_idx) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = words[grant_idx];
            out_sel_d   = grant_idx;
            if (MODE == 0) begin
                ptr_d = (grant_idx == SELW'(NCH-1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: round-robin (NCH=4 and NCH=3) and fixed-priority instances.
module tb_rr_mux_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: MODE 0, NCH 4
    logic [3:0]  a_iv, a_ir;
    logic [31:0] a_id;
    logic        a_ov, a_or;
    logic [7:0]  a_od;
    logic [1:0]  a_os;
    // Instance B: MODE 1, NCH 4
    logic [3:0]  b_iv, b_ir;
    logic [31:0] b_id;
    logic        b_ov, b_or;
    logic [7:0]  b_od;
    logic [1:0]  b_os;
    // Instance C: MODE 0, NCH 3
    logic [2:0]  c_iv, c_ir;
    logic [23:0] c_id;
    logic        c_ov, c_or;
    logic [7:0]  c_od;
    logic [1:0]  c_os;

    int checks = 0;
    int errors = 0;

    rr_mux_reg #(.WIDTH(8), .NCH(4), .MODE(0)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_or));
    rr_mux_reg #(.WIDTH(8), .NCH(4), .MODE(1)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(b_or));
    rr_mux_reg #(.WIDTH(8), .NCH(3), .MODE(0)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_sel(c_os), .out_ready(c_or));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, ".a_valid"}, 32'(a_ov), 32'(v));
        chk({tag, ".a_data"},  32'(a_od), 32'(d));
        chk({tag, ".a_sel"},   32'(a_os), 32'(s));
    endtask

    initial begin
        a_id = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_id = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        c_id = {8'hC2, 8'hC1, 8'hC0};
        a_iv = 4'b1111; a_or = 1'b1;
        b_iv = 4'b0000; b_or = 1'b1;
        c_iv = 3'b000;  c_or = 1'b1;
        reset = 1'b1;

        // Reset with all channels requesting
        tick(); tick();
        chk_a("rst", 1'b0, 8'h00, 2'd0);
        chk("rst.a_ready", 32'(a_ir), 32'h0);
        chk("rst.b_valid", 32'(b_ov), 32'h0);
        chk("rst.c_sel",   32'(c_os), 32'h0);
        reset = 1'b0;
        #1;
        chk("rel.a_ready", 32'(a_ir), 32'h1);

        // Full round-robin rotation, one word per cycle
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_a($sformatf("rr%0d", k), 1'b1, 8'hA0 + 8'(k % 4), 2'(k % 4));
        end

        // Backpressure: held word stays, no accepts
        a_or = 1'b0;
        #1;
        chk("bp.ready0", 32'(a_ir), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_a($sformatf("bp%0d", k), 1'b1, 8'hA3, 2'd3);
            chk($sformatf("bp%0d.ready", k), 32'(a_ir), 32'h0);
        end
        a_or = 1'b1;
        #1;
        chk("bp.release_ready", 32'(a_ir), 32'h1);
        tick();
        chk_a("bp.load", 1'b1, 8'hA0, 2'd0);

        // Move pointer to 2 by granting channel 1, then sparse requests 0011
        a_iv = 4'b0010;
        tick();
        chk_a("sp.ptr2", 1'b1, 8'hA1, 2'd1);
        a_iv = 4'b0011;
        #1;
        chk("sp.ready0", 32'(a_ir), 32'h1);
        tick();
        chk_a("sp.g0", 1'b1, 8'hA0, 2'd0);
        chk("sp.ready1", 32'(a_ir), 32'h2);
        tick();
        chk_a("sp.g1", 1'b1, 8'hA1, 2'd1);

        // Idle drain: register empties, data/sel hold, pointer stays at 2
        a_iv = 4'b0000;
        tick();
        chk_a("idle", 1'b0, 8'hA1, 2'd1);
        chk("idle.ready", 32'(a_ir), 32'h0);
        a_iv = 4'b1111; a_or = 1'b0;
        #1;
        chk("idle.ptr", 32'(a_ir), 32'h4);
        tick();
        chk_a("idle.reload", 1'b1, 8'hA2, 2'd2);
        a_or = 1'b1;

        // Mid-operation reset drops the held word and the pointer
        #2;
        reset = 1'b1;
        #1;
        chk_a("mrst", 1'b0, 8'h00, 2'd0);
        chk("mrst.ready", 32'(a_ir), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("mrst.ptr", 32'(a_ir), 32'h1);
        a_iv = 4'b0000;

        // Fixed priority: channel 1 beats channel 3 every cycle
        b_iv = 4'b1010;
        #1;
        chk("fp.ready", 32'(b_ir), 32'h2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fp%0d.sel", k),  32'(b_os), 32'd1);
            chk($sformatf("fp%0d.data", k), 32'(b_od), 32'hB1);
            chk($sformatf("fp%0d.ready", k), 32'(b_ir), 32'h2);
        end
        b_iv = 4'b1000;
        #1;
        chk("fp3.ready", 32'(b_ir), 32'h8);
        tick();
        chk("fp3.sel",  32'(b_os), 32'd3);
        chk("fp3.data", 32'(b_od), 32'hB3);
        b_iv = 4'b0000;

        // Non-power-of-two round-robin wraps 2 -> 0
        c_iv = 3'b111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("np%0d.sel", k),  32'(c_os), 32'(k % 3));
            chk($sformatf("np%0d.data", k), 32'(c_od), 32'hC0 + 32'(k % 3));
            chk($sformatf("np%0d.valid", k), 32'(c_ov), 32'h1);
        end
        c_iv = 3'b000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
